uart_tx_sched: RTL

Round-robin scheduler that shares one UART byte transmitter between `NUM_REQ` byte producers. Generates the transmitter's baud-tick enable, arbitrates pending bytes, drives the transmitter's data/valid handshake, and paces issue on the transmitter's busy/done outputs. Supports multi-byte frames: a requester keeps the transmitter until it sends a byte marked last.

---
 rtl/uart_tx_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART byte transmitter between NUM_REQ byte producers.
//   A free-running counter produces the transmitter's baud tick. A round-robin
//   arbiter picks a pending byte, loads it into the transmitter, and then waits
//   on the transmitter's busy/done outputs before it picks again. A requester
//   that sends a byte not marked last keeps the grant until its frame ends.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   reqValid  : per-requester byte pending
//   reqData   : per-requester byte, requester i in [8i+7:8i]
//   reqLast   : per-requester frame-end flag for the pending byte
//   reqReady  : per-requester one-cycle accept pulse
//   txEn      : baud tick to the transmitter (one cycle every BAUD_DIV)
//   txData    : byte to the transmitter
//   txValid   : byte-load strobe to the transmitter
//   txBusy    : transmitter busy, start bit through stop bit
//   txDone    : transmitter entered its stop bit (one pulse per byte)
//   grantId   : current or last granted requester
//   locked    : frame in progress, grant held
module uart_tx_sched #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 868,
  parameter int CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [8*NUM_REQ-1:0]       reqData,
  input  logic [NUM_REQ-1:0]         reqLast,
  output logic [NUM_REQ-1:0]         reqReady,
  output logic                       txEn,
  output logic [7:0]                 txData,
  output logic                       txValid,
  input  logic                       txBusy,
  input  logic                       txDone,
  output logic [$clog2(NUM_REQ)-1:0] grantId,
  output logic                       locked
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  baud_cnt;
  logic [ID_W-1:0]   rr_ptr;
  logic              frame_end;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;

  // txEn is registered, so it is raised one count early to be high while the
  // counter sits at BAUD_DIV-1; the first tick lands on cycle BAUD_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      txEn     <= 1'b0;
    end else begin
      baud_cnt <= (baud_cnt == CNT_W'(BAUD_DIV - 1)) ? '0 : baud_cnt + CNT_W'(1);
      txEn     <= (baud_cnt == CNT_W'(BAUD_DIV - 2));
    end
  end

  // While a frame is open only the lock holder is eligible, so the search
  // start point does not matter in that case.
  always_comb begin
    elig       = reqValid;
    cand       = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    if (locked) elig = reqValid & (NUM_REQ'(1) << grantId);
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Waiting on txDone (stop-bit entry) rather than on busy falling lets the
  // next byte load during the stop bit, so frames go out back to back.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (txBusy) state_next = WAIT_DONE;
      WAIT_DONE: if (txDone) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    txValid  = 1'b0;
    reqReady = '0;
    if (state == ISSUE) begin
      txValid           = 1'b1;
      reqReady[grantId] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      locked    <= 1'b0;
      grantId   <= '0;
      txData    <= '0;
      frame_end <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_found) begin
        grantId   <= pick_id;
        txData    <= reqData[{pick_id, 3'b000} +: 8];
        frame_end <= reqLast[pick_id];
      end
      // The pointer only moves when a frame closes, so a multi-byte frame
      // does not skew fairness between requesters.
      if (state == ISSUE) begin
        if (frame_end) begin
          locked <= 1'b0;
          rr_ptr <= (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + ID_W'(1);
        end else begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule
